seq_multiplier_param: RTL and testbench

- Parametrised sequential shift-and-add multiplier with a start/busy/done handshake.
- Successor to the fixed 8-bit unsigned multiplier: configurable WIDTH, full 2*WIDTH product, signed or unsigned mode per operation, and an overflow flag.
- Sits beside the sequential shifter in the processor datapath. It processes one multiplier bit per cycle.

---
 rtl/seq_multiplier_param_if.sv | 24 ++
 rtl/seq_multiplier_param.sv | 129 ++++++++++++
 tb/tb_seq_multiplier_param.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_param_if.sv
// Operand/result bundle for seq_multiplier_param: start request, operands and mode
// in, full product, overflow and busy/done handshake out.
interface seq_multiplier_param_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 mode_signed;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2*WIDTH-1:0]   product;
   logic                 ovf;
   logic                 busy;
   logic                 done;

   modport master (
      output start, mode_signed, a, b,
      input  product, ovf, busy, done
   );

   modport slave (
      input  start, mode_signed, a, b,
      output product, ovf, busy, done
   );
endinterface

// File: rtl/seq_multiplier_param.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle, signed/unsigned per op.
// Define SEQ_MUL_EARLY_TERM_EN to stop iterating once the remaining multiplier bits are zero.
module seq_multiplier_param #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic                  clk,
   input logic                  rst_n,
   seq_multiplier_param_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t               state_q, state_d;
   logic                 mode_q, mode_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     mreg_q, mreg_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 ovf_q, ovf_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   prod_final;
   logic [WIDTH:0]       prod_top;
   logic                 ovf_final;

   // Negating -2^(W-1) yields the same bit pattern, which read unsigned is the correct magnitude.
   always_comb begin
      a_mag = (bus.mode_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
      b_mag = (bus.mode_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
   end

   always_comb begin
      prod_final = neg_q ? (~acc_q + 1'b1) : acc_q;
      prod_top   = prod_final[2*WIDTH-1:WIDTH-1];
      if (mode_q) begin
         ovf_final = !((&prod_top) || (~|prod_top));
      end else begin
         ovf_final = |prod_final[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      neg_d     = neg_q;
      mreg_d    = mreg_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mode_d  = bus.mode_signed;
               neg_d   = bus.mode_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               mreg_d  = b_mag;
               mcand_d = {{WIDTH{1'b0}}, a_mag};
               acc_d   = '0;
               count_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef SEQ_MUL_EARLY_TERM_EN
            if (mreg_q == '0) begin
               state_d = FIN;
            end else begin
               if (mreg_q[0]) acc_d = acc_q + mcand_q;
               mcand_d = mcand_q << 1;
               mreg_d  = mreg_q >> 1;
               count_d = count_q + 1'b1;
               // Leave on the edge that consumes the last set bit.
               if ((mreg_q[WIDTH-1:1] == '0) || (count_d == CNT_W'(WIDTH))) state_d = FIN;
            end
`else
            if (mreg_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            mreg_d  = mreg_q >> 1;
            count_d = count_q + 1'b1;
            if (count_d == CNT_W'(WIDTH)) state_d = FIN;
`endif
         end
         FIN: begin
            product_d = prod_final;
            ovf_d     = ovf_final;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mode_q    <= 1'b0;
         neg_q     <= 1'b0;
         mreg_q    <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         neg_q     <= neg_d;
         mreg_q    <= mreg_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign bus.product = product_q;
   assign bus.ovf     = ovf_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_multiplier_param.sv
// Scoreboard bench for seq_multiplier_param (WIDTH=8): expected results queued at issue,
// popped and compared when done is seen.
module tb_seq_multiplier_param;
   localparam int W = 8;

   typedef struct {
      logic [2*W-1:0] p;
      logic           ovf;
      int             lat;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           m;
      string          tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   seq_multiplier_param_if #(.WIDTH(W)) bus ();
   seq_multiplier_param #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      exp_t e;
      int   p;
      if (m) begin
         p     = int'($signed(a)) * int'($signed(b));
         e.ovf = (p > 127) || (p < -128);
      end else begin
         p     = int'(a) * int'(b);
         e.ovf = (p > 255);
      end
      e.p = p[2*W-1:0];
      e.a = a;
      e.b = b;
      e.m = m;
      return e;
   endfunction

   function automatic int exp_lat(input logic [W-1:0] b, input logic m);
`ifdef SEQ_MUL_EARLY_TERM_EN
      logic [W-1:0] mag;
      int           n;
      mag = (m && b[W-1]) ? (~b + 1'b1) : b;
      n   = 0;
      for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
      return ((n == 0) ? 1 : n) + 1;
`else
      return W + 1;
`endif
   endfunction

   // Called at a negedge; start is sampled by the next rising edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input string tag);
      exp_t e;
      e     = model(a, b, m);
      e.lat = exp_lat(b, m);
      e.tag = tag;
      sb.push_back(e);
      bus.a           = a;
      bus.b           = b;
      bus.mode_signed = m;
      bus.start       = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int elapsed, output int busy_cnt);
      int   cyc;
      exp_t e;
      cyc      = elapsed;
      busy_cnt = 0;
      while (bus.done !== 1'b1 && cyc < 64) begin
         if (bus.busy === 1'b1) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
      if (bus.done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL done_timeout: no done after %0d cycles, required one", cyc);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_done: product=%h with empty scoreboard", bus.product);
      end else begin
         e = sb.pop_front();
         checks += 3;
         if (bus.product !== e.p) begin
            errors++;
            $display("FAIL %s product: got %h, required %h", e.tag, bus.product, e.p);
         end
         if (bus.ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s ovf: got %b, required %b", e.tag, bus.ovf, e.ovf);
         end
         if (cyc != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", e.tag, cyc, e.lat);
         end
         $display("op %-10s m=%b a=%h b=%h -> product=%h ovf=%b latency=%0d",
                  e.tag, e.m, e.a, e.b, bus.product, bus.ovf, cyc);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.mode_signed = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 4;
      if (bus.product !== '0) begin errors++; $display("FAIL reset_product: got %h, required 0", bus.product); end
      if (bus.ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf: got %b, required 0", bus.ovf); end
      if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
      if (bus.done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b, required 0", bus.done); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      int bc;
      issue(8'd13, 8'd11, 1'b0, "u13x11");
      wait_done(0, bc);
`ifndef SEQ_MUL_EARLY_TERM_EN
      checks++;
      if (bc != 9) begin errors++; $display("FAIL busy_cycles: got %0d, required 9", bc); end
`endif
      @(negedge clk);
      checks += 2;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b one cycle later, required 0", bus.done); end
      if (bus.product !== 16'h008F) begin errors++; $display("FAIL product_hold: got %h, required 008f", bus.product); end
      issue(8'hFF, 8'hFF, 1'b0, "u255x255");
      wait_done(0, bc);
   endtask

   task automatic test_signed();
      int bc;
      issue(8'hFD, 8'h05, 1'b1, "s-3x5");
      wait_done(0, bc);
      issue(8'h80, 8'h80, 1'b1, "s80x80");
      wait_done(0, bc);
      issue(8'h80, 8'h01, 1'b1, "s80x01");
      wait_done(0, bc);
      issue(8'h7F, 8'h80, 1'b1, "s7Fx80");
      wait_done(0, bc);
   endtask

   task automatic test_ignore_busy();
      int  bc;
      bit  extra;
      issue(8'd20, 8'd3, 1'b0, "first");
      bus.a = 8'd99; bus.b = 8'd77; bus.mode_signed = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(3, bc);
      extra = 1'b0;
      repeat (14) begin
         @(negedge clk);
         if (bus.done === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra) begin errors++; $display("FAIL ignored_start: got an extra done, required none"); end
   endtask

   task automatic test_back_to_back();
      int bc;
      issue(8'd100, 8'd2, 1'b0, "b2b_1");
      wait_done(0, bc);
      issue(8'hF0, 8'h10, 1'b1, "b2b_2");
      wait_done(0, bc);
      for (int i = 0; i < 10; i++) begin
         issue(W'($urandom), W'($urandom), i[0], $sformatf("rnd%0d", i));
         wait_done(0, bc);
      end
   endtask

   task automatic test_reset_mid();
      int bc;
      bit seen;
      issue(8'h5A, 8'h3C, 1'b0, "aborted");
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (bus.product !== '0) begin errors++; $display("FAIL abort_product: got %h, required 0", bus.product); end
      if (bus.ovf !== 1'b0)   begin errors++; $display("FAIL abort_ovf: got %b, required 0", bus.ovf); end
      if (bus.busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b, required 0", bus.busy); end
      if (bus.done !== 1'b0)  begin errors++; $display("FAIL abort_done: got %b, required 0", bus.done); end
      sb.delete();
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL abort_no_done: got a done pulse, required none"); end
      issue(8'd9, 8'd6, 1'b0, "post_rst");
      wait_done(0, bc);
   endtask

   task automatic test_early_term();
      int bc;
      issue(8'd7, 8'd3, 1'b0, "e7x3");
      wait_done(0, bc);
      issue(8'd7, 8'd0, 1'b0, "e7x0");
      wait_done(0, bc);
      issue(8'hFF, 8'hFF, 1'b1, "e-1x-1");
      wait_done(0, bc);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      test_early_term();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
